// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester round-robin write-back arbiter with a registered write port and a pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stall,
  input  logic              req0_valid,
  input  logic [AW-1:0]     req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [AW-1:0]     req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_set_reg,
  output logic              RegWrite,
  output logic [AW-1:0]     Wreg,
  output logic [DATA_W-1:0] Wdata,
  output logic [2**AW-1:0]  busy
);
  logic              ptr;
  logic              grant;
  logic [AW-1:0]     g_reg;
  logic [DATA_W-1:0] g_data;
  logic [2**AW-1:0]  busy_nx;
  always_comb begin
    req0_ready = rst_n & ~wb_stall & req0_valid & (~req1_valid | ~ptr);
    req1_ready = rst_n & ~wb_stall & req1_valid & (~req0_valid | ptr);
    grant = req0_ready | req1_ready;
    g_reg = req1_ready ? req1_reg : req0_reg;
    g_data = req1_ready ? req1_data : req0_data;
    busy_nx = busy;
    if (RegWrite) busy_nx[Wreg] = 1'b0;
    // set is applied after clear so a same-edge set on the written register wins
    if (sb_set) busy_nx[sb_set_reg] = 1'b1;
    busy_nx[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
      RegWrite <= 1'b0;
      Wreg <= '0;
      Wdata <= '0;
      busy <= '0;
    end else begin
      RegWrite <= grant && (g_reg != '0);
      if (grant) begin
        Wreg <= g_reg;
        Wdata <= g_data;
        ptr <= req0_ready;
      end
      busy <= busy_nx;
    end
  end
endmodule
